// File: rtl/mmio_mailbox_m_pkg.sv
// Shared constants and types for the MMIO mailbox: bus widths, register offsets
// and the STATUS register layout.
package mmio_mailbox_m_pkg;

  localparam int unsigned MBOX_ADDR_WIDTH = 16;
  localparam int unsigned MBOX_DATA_WIDTH = 8;
  localparam int unsigned MBOX_OFF_WIDTH  = 3;

  localparam logic [MBOX_OFF_WIDTH-1:0] MBOX_DATA    = 3'd0;
  localparam logic [MBOX_OFF_WIDTH-1:0] MBOX_STATUS  = 3'd1;
  localparam logic [MBOX_OFF_WIDTH-1:0] MBOX_SCRATCH = 3'd2;
  localparam logic [MBOX_OFF_WIDTH-1:0] MBOX_COUNT   = 3'd3;

  localparam int unsigned ST_RX_EMPTY = 0;
  localparam int unsigned ST_RX_FULL  = 1;
  localparam int unsigned ST_TX_EMPTY = 2;
  localparam int unsigned ST_TX_FULL  = 3;
  localparam int unsigned ST_TX_OVF   = 4;
  localparam int unsigned ST_RX_UNF   = 5;

  // Field order matches the ST_* bit indices (rx_empty is bit 0).
  typedef struct packed {
    logic rx_unf;
    logic tx_ovf;
    logic tx_full;
    logic tx_empty;
    logic rx_full;
    logic rx_empty;
  } mbox_status_t;

  function automatic logic [7:0] pack_status(input mbox_status_t s);
    return {2'b00, s};
  endfunction

endpackage

// File: rtl/mmio_mailbox_m_if.sv
// Mailbox signal bundle: CPU-side address/strobes plus the TX and RX streams.
interface mmio_mailbox_m_if
  import mmio_mailbox_m_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MBOX_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MBOX_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] address_bus;
  logic                  OE_M;
  logic                  WE_M;

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  // master: CPU initiator plus external consumer/producer; slave: the mailbox.
  modport master (
    output address_bus, OE_M, WE_M, tx_ready, rx_data, rx_valid,
    input  tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  address_bus, OE_M, WE_M, tx_ready, rx_data, rx_valid,
    output tx_data, tx_valid, rx_ready
  );

endinterface

// File: rtl/mmio_mailbox_m_sync_fifo.sv
// Small synchronous FIFO; pushes while full and pops while empty are ignored,
// and the head reads as zero when empty.
module sync_fifo_m #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_mailbox_m.sv
// MMIO mailbox responder: decodes an 8-byte I/O window on the CPU bus, with a
// CPU-to-consumer TX FIFO, a producer-to-CPU RX FIFO, status and scratch.
module mmio_mailbox_m
  import mmio_mailbox_m_pkg::*;
#(
  parameter int unsigned         ADDR_WIDTH = MBOX_ADDR_WIDTH,
  parameter int unsigned         DATA_WIDTH = MBOX_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(16'h8000),
  parameter int unsigned         FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_mailbox_m_if.slave       bus,
  inout  wire  [DATA_WIDTH-1:0] data_bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                      sel;
  logic [MBOX_OFF_WIDTH-1:0] off;
  logic                      is_write;
  logic                      rd_acc;
  logic                      access;
  logic                      start;
  logic                      wr_start;
  logic                      rd_start;
  logic [DATA_WIDTH-1:0]     wdata;

  logic                      prev_active;
  logic [MBOX_OFF_WIDTH-1:0] prev_off;
  logic                      prev_we;
  logic [DATA_WIDTH-1:0]     rd_hold;
  logic [DATA_WIDTH-1:0]     scratch;
  logic                      tx_ovf;
  logic                      rx_unf;

  logic                      tx_push;
  logic [DATA_WIDTH-1:0]     tx_dout;
  logic                      tx_full;
  logic                      tx_empty;
  logic [CNT_W-1:0]          tx_count;

  logic                      rx_pop;
  logic [DATA_WIDTH-1:0]     rx_dout;
  logic                      rx_full;
  logic                      rx_empty;
  logic [CNT_W-1:0]          rx_count;

  logic                      tx_ovf_set;
  logic                      tx_ovf_clr;
  logic                      rx_unf_set;
  logic                      rx_unf_clr;

  mbox_status_t              status;
  logic [DATA_WIDTH-1:0]     rd_live;
  logic [DATA_WIDTH-1:0]     rd_val_c;
  logic                      drive_c;

  // Window decode; a cycle with both strobes high is a write.
  assign sel      = (bus.address_bus[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]);
  assign off      = bus.address_bus[2:0];
  assign is_write = sel & bus.WE_M;
  assign rd_acc   = sel & bus.OE_M & ~bus.WE_M;
  assign access   = is_write | rd_acc;
  assign wdata    = data_bus;

  // A held strobe on the same register and direction is one access.
  assign start    = access & ~(prev_active & (prev_off == off) & (prev_we == is_write));
  assign wr_start = start & is_write;
  assign rd_start = start & rd_acc;

  assign tx_push    = wr_start & (off == MBOX_DATA);
  assign rx_pop     = rd_start & (off == MBOX_DATA);
  assign tx_ovf_set = tx_push & tx_full;
  assign rx_unf_set = rx_pop & rx_empty;
  assign tx_ovf_clr = wr_start & (off == MBOX_STATUS) & wdata[ST_TX_OVF];
  assign rx_unf_clr = wr_start & (off == MBOX_STATUS) & wdata[ST_RX_UNF];

  sync_fifo_m #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (bus.tx_ready),
    .din   (wdata),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo_m #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.rx_valid),
    .pop   (rx_pop),
    .din   (bus.rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign bus.tx_data  = tx_dout;
  assign bus.tx_valid = ~tx_empty;
  assign bus.rx_ready = ~rx_full;

  always_comb begin
    status          = '0;
    status.rx_empty = rx_empty;
    status.rx_full  = rx_full;
    status.tx_empty = tx_empty;
    status.tx_full  = tx_full;
    status.tx_ovf   = tx_ovf;
    status.rx_unf   = rx_unf;
  end

  // Live register view, used on the start cycle and captured into rd_hold.
  always_comb begin
    rd_live = '0;
    case (off)
      MBOX_DATA:    rd_live = rx_dout;
      MBOX_STATUS:  rd_live = DATA_WIDTH'(pack_status(status));
      MBOX_SCRATCH: rd_live = scratch;
      MBOX_COUNT:   rd_live = DATA_WIDTH'({4'(rx_count), 4'(tx_count)});
      default:      rd_live = '0;
    endcase
  end

  assign rd_val_c = start ? rd_live : rd_hold;
  assign drive_c  = rd_acc & ~reset;
  assign data_bus = drive_c ? rd_val_c : 'z;

  // A sticky set in the same cycle as its clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_active <= 1'b0;
      prev_off    <= '0;
      prev_we     <= 1'b0;
      rd_hold     <= '0;
      scratch     <= '0;
      tx_ovf      <= 1'b0;
      rx_unf      <= 1'b0;
    end else begin
      prev_active <= access;
      prev_off    <= off;
      prev_we     <= is_write;
      if (rd_start) rd_hold <= rd_live;
      if (wr_start && (off == MBOX_SCRATCH)) scratch <= wdata;
      tx_ovf <= tx_ovf_set | (tx_ovf & ~tx_ovf_clr);
      rx_unf <= rx_unf_set | (rx_unf & ~rx_unf_clr);
    end
  end

endmodule

// File: tb/tb_mmio_mailbox_m.sv
// Scoreboard bench for mmio_mailbox_m: a queue-based reference model predicts
// read data, stream handshakes and flags; a negedge monitor compares.
module tb_mmio_mailbox_m;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  ZVAL  = 8'hFF;

  logic clk = 1'b0;
  logic reset;
  tri1 [7:0] data_bus;
  logic       tb_drv;
  logic [7:0] tb_wdata;

  assign data_bus = tb_drv ? tb_wdata : 8'bz;

  mmio_mailbox_m_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  mmio_mailbox_m #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .BASE_ADDR  (16'h8000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .data_bus (data_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
  } flags_t;

  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [7:0] m_scratch;
  logic [7:0] m_hold;
  bit         m_ovf;
  bit         m_unf;
  bit         m_known;

  flags_t     exp_flags[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_tx[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_live(input logic [2:0] off);
    int txn = m_tx.size();
    int rxn = m_rx.size();
    case (off)
      3'd0:    return (rxn > 0) ? m_rx[0] : 8'h00;
      3'd1:    return {2'b00, m_unf, m_ovf, txn == DEPTH, txn == 0, rxn == DEPTH, rxn == 0};
      3'd2:    return m_scratch;
      3'd3:    return {4'(rxn), 4'(txn)};
      default: return 8'h00;
    endcase
  endfunction

  // One clock of stimulus: predict outputs from pre-edge model state, then
  // apply the edge's effects to the model.
  task automatic cycle(input bit rst, input bit oe, input bit we, input logic [2:0] off,
                       input logic [7:0] wd, input bit first, input bit txr,
                       input bit rxv, input logic [7:0] rxd);
    int txn;
    int rxn;
    logic [7:0] live;
    flags_t f;
    reset           = rst;
    bus.OE_M        = oe;
    bus.WE_M        = we;
    bus.address_bus = 16'h8000 | 16'(off);
    tb_drv          = we;
    tb_wdata        = wd;
    bus.tx_ready    = txr;
    bus.rx_valid    = rxv;
    bus.rx_data     = rxd;
    txn  = m_tx.size();
    rxn  = m_rx.size();
    live = model_live(off);
    if (m_known) begin
      f.tx_valid = (txn > 0);
      f.rx_ready = (rxn < DEPTH);
      f.tx_data  = (txn > 0) ? m_tx[0] : 8'h00;
      exp_flags.push_back(f);
    end
    if (oe && !we) exp_rd.push_back(rst ? ZVAL : (first ? live : m_hold));
    if (m_known && txn > 0 && txr) exp_tx.push_back(m_tx[0]);
    @(posedge clk);
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      m_scratch = 8'h00;
      m_hold    = 8'h00;
      m_ovf     = 1'b0;
      m_unf     = 1'b0;
      m_known   = 1'b1;
    end else begin
      if (txn > 0 && txr) void'(m_tx.pop_front());
      if (first && we) begin
        case (off)
          3'd0: begin
            if (txn == DEPTH) m_ovf = 1'b1;
            else m_tx.push_back(wd);
          end
          3'd1: begin
            if (wd[4]) m_ovf = 1'b0;
            if (wd[5]) m_unf = 1'b0;
          end
          3'd2: m_scratch = wd;
          default: ;
        endcase
      end else if (first && oe) begin
        m_hold = live;
        if (off == 3'd0) begin
          if (rxn == 0) m_unf = 1'b1;
          else void'(m_rx.pop_front());
        end
      end
      if (rxv && rxn < DEPTH) m_rx.push_back(rxd);
    end
    #1;
  endtask

  task automatic idle(input int n, input bit txr, input bit rxv, input logic [7:0] rxd);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, txr, rxv, rxd);
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d, input int hold);
    for (int i = 0; i < hold; i++) cycle(1'b0, 1'b0, 1'b1, off, d, i == 0, 1'b0, 1'b0, 8'h00);
    idle(1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [2:0] off, input int hold);
    for (int i = 0; i < hold; i++) cycle(1'b0, 1'b1, 1'b0, off, 8'h00, i == 0, 1'b0, 1'b0, 8'h00);
    idle(1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rand_access(input bit we, input logic [2:0] off, input logic [7:0] wd, input int hold);
    for (int i = 0; i < hold; i++)
      cycle(1'b0, we ? 1'($urandom_range(0, 1)) : 1'b1, we, off, wd, i == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  // Monitor: flags every cycle, read data whenever a read strobe is presented,
  // high-Z when the bus is idle, and each TX handshake against the scoreboard.
  always @(negedge clk) begin
    flags_t f;
    if (exp_flags.size() > 0) begin
      f = exp_flags.pop_front();
      check("tx_valid", 32'(bus.tx_valid), 32'(f.tx_valid));
      check("rx_ready", 32'(bus.rx_ready), 32'(f.rx_ready));
      check("tx_data",  32'(bus.tx_data),  32'(f.tx_data));
    end
    if (bus.OE_M === 1'b1 && bus.WE_M === 1'b0) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: got %0h expected no read at %0t", data_bus, $time);
      end else begin
        check("rd_data", 32'(data_bus), 32'(exp_rd.pop_front()));
      end
    end else if (bus.WE_M !== 1'b1) begin
      check("bus_idle_z", 32'(data_bus), 32'(ZVAL));
    end
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      if (exp_tx.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_unexpected: got %0h expected no transfer at %0t", bus.tx_data, $time);
      end else begin
        check("tx_stream", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  initial begin
    reset           = 1'b1;
    bus.OE_M        = 1'b0;
    bus.WE_M        = 1'b0;
    bus.address_bus = 16'h8000;
    bus.tx_ready    = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    tb_drv          = 1'b0;
    tb_wdata        = 8'h00;
    m_known         = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset state
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2, 1'b0, 1'b0, 8'h00);
    rd(3'd1, 1);
    rd(3'd3, 1);

    // 2: scratch, including a write held for three cycles
    wr(3'd2, 8'h25, 1);
    rd(3'd2, 1);
    wr(3'd2, 8'h8F, 3);
    rd(3'd2, 1);
    rd(3'd3, 1);
    rd(3'd1, 1);

    // 3: TX overflow, drain, sticky clear
    for (int i = 1; i <= 5; i++) wr(3'd0, 8'hA0 + 8'(i), 1);
    rd(3'd3, 1);
    rd(3'd1, 1);
    idle(6, 1'b1, 1'b0, 8'h00);
    rd(3'd1, 1);
    wr(3'd1, 8'h10, 1);
    rd(3'd1, 1);

    // 4: held DATA read pops once; underflow
    idle(1, 1'b0, 1'b1, 8'h11);
    idle(1, 1'b0, 1'b1, 8'h22);
    rd(3'd0, 2);
    rd(3'd3, 1);
    rd(3'd0, 1);
    rd(3'd0, 1);
    rd(3'd1, 1);
    wr(3'd1, 8'h30, 1);

    // 5: RX full, then pop with simultaneous producer push
    for (int i = 1; i <= 4; i++) idle(1, 1'b0, 1'b1, 8'h30 + 8'(i));
    idle(1, 1'b0, 1'b1, 8'h3F);
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h55);
    idle(1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h66);
    idle(1, 1'b0, 1'b0, 8'h00);
    rd(3'd3, 1);
    for (int i = 0; i < 3; i++) rd(3'd0, 1);
    rd(3'd1, 1);

    // 6: reset in the middle of a held DATA read
    for (int i = 0; i < 3; i++) idle(1, 1'b0, 1'b1, 8'h70 + 8'(i));
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(1, 1'b0, 1'b0, 8'h00);
    rd(3'd3, 1);
    rd(3'd1, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [2:0] off;
      off = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      if ($urandom_range(0, 39) == 0) begin
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      end else begin
        rand_access(1'($urandom_range(0, 1)), off, 8'($urandom), $urandom_range(1, 3));
      end
      idle($urandom_range(1, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    idle(3, 1'b0, 1'b0, 8'h00);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
